// File: rtl/ps2_kbd_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_kbd_tx_if
// Purpose : bundles the byte-write handshake, host inhibit, status flags and
//           the two PS/2 lines of the keyboard-side transmitter.
// Signals : din          - scan-code byte to queue
//           we           - one-cycle write strobe (ignored while full)
//           inhibit      - host holding the PS/2 clock low
//           full         - byte FIFO is at capacity
//           busy         - frame/gap in progress, retry pending or FIFO non-empty
//           ps2_kbd_clk  - PS/2 clock toward the receiver, idle high
//           ps2_kbd_data - PS/2 data toward the receiver, idle high
// Modports: master drives din/we/inhibit, slave is the transmitter.
// ----------------------------------------------------------------------------
interface ps2_kbd_tx_if;
    logic [7:0] din;
    logic       we;
    logic       inhibit;
    logic       full;
    logic       busy;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;

    modport master (
        output din,
        output we,
        output inhibit,
        input  full,
        input  busy,
        input  ps2_kbd_clk,
        input  ps2_kbd_data
    );

    modport slave (
        input  din,
        input  we,
        input  inhibit,
        output full,
        output busy,
        output ps2_kbd_clk,
        output ps2_kbd_data
    );
endinterface

// File: rtl/ps2_kbd_tx.sv
// ----------------------------------------------------------------------------
// ps2_kbd_tx
// Purpose : keyboard-side PS/2 transmitter. Bytes written through the
//           interface are queued in a small FIFO and sent as 11-bit frames
//           (start 0, 8 data bits LSB first, odd parity, stop 1) on a
//           self-generated PS/2 clock, with an idle gap after every frame.
//           A host inhibit before the parity bit's falling clock edge aborts
//           the frame; the byte is kept and resent after the gap.
// Ports   : clk_sys - system clock, all logic on its rising edge
//           rst_n   - asynchronous active-low reset
//           bus     - ps2_kbd_tx_if.slave (din, we, inhibit, full, busy,
//                     ps2_kbd_clk, ps2_kbd_data)
// Params  : HALF_PERIOD - clk_sys cycles per PS/2 clock half-period (>= 4)
//           GAP_HALVES  - idle half-periods after each frame
//           FIFO_DEPTH  - byte FIFO depth, power of two in 2..16
// ----------------------------------------------------------------------------
module ps2_kbd_tx #(
    parameter int HALF_PERIOD = 4000,
    parameter int GAP_HALVES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    ps2_kbd_tx_if.slave bus
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int GAP_CYC  = GAP_HALVES * HALF_PERIOD;
    localparam int MAX_CYC  = (GAP_CYC > HALF_PERIOD) ? GAP_CYC : HALF_PERIOD;
    localparam int CW       = $clog2(MAX_CYC + 1);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   occ_t;
    typedef logic [CW-1:0] tmr_t;

    localparam occ_t DEPTH_C   = occ_t'(FIFO_DEPTH);
    localparam tmr_t HP_LAST   = tmr_t'(HALF_PERIOD - 1);
    localparam tmr_t HALF_LAST = tmr_t'(HALF_PERIOD / 2 - 1);
    localparam tmr_t GAP_LAST  = tmr_t'(GAP_CYC - 1);

    // Frame bit positions: 0 start, 1..8 data, 9 parity, 10 stop.
    localparam logic [3:0] PARITY_IDX = 4'd9;
    localparam logic [3:0] STOP_IDX   = 4'd10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        GAP    = 3'd4
    } state_t;

    // Odd parity: bit is 1 when the data holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    // Assemble the on-wire frame, bit 0 transmitted first.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, odd_parity(b), b, 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [FIFO_DEPTH];
    ptr_t        r_wr_ptr;
    ptr_t        r_rd_ptr;
    occ_t        r_count;
    logic        r_full;
    logic        r_busy;

    state_t      r_state;
    tmr_t        r_tmr;
    logic [3:0]  r_idx;
    logic [10:0] r_frame;
    logic        r_retry;       // r_frame holds an aborted byte awaiting resend
    logic        r_ps2_clk;
    logic        r_ps2_data;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_nempty;
    occ_t        w_count_nxt;
    state_t      w_state_nxt;
    tmr_t        w_tmr_nxt;
    logic [3:0]  w_idx_nxt;
    logic [10:0] w_frame_nxt;
    logic        w_retry_nxt;
    logic        w_clk_nxt;
    logic        w_data_nxt;
    logic        w_cur_bit;

    assign w_push        = bus.we & ~r_full;
    assign w_fifo_nempty = (r_count != occ_t'(0));
    assign w_cur_bit     = r_frame[r_idx];

    // FIFO occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + occ_t'(1);
            2'b01:   w_count_nxt = r_count - occ_t'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Frame sequencer: next state, timer, bit index and line levels.
    // Line levels are computed from the current state and registered, so
    // the wires lag the state by one cycle; an abort forces both high on
    // the same edge that enters GAP.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + tmr_t'(1);
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        w_retry_nxt = r_retry;
        w_pop       = 1'b0;
        w_clk_nxt   = 1'b1;
        w_data_nxt  = 1'b1;
        case (r_state)
            IDLE: begin
                w_tmr_nxt = tmr_t'(0);
                if (!bus.inhibit && (r_retry || w_fifo_nempty)) begin
                    w_state_nxt = SETUP;
                    w_idx_nxt   = 4'd0;
                    if (r_retry) begin
                        // Aborted frame is still in r_frame; resend it first.
                        w_retry_nxt = 1'b0;
                    end else begin
                        w_frame_nxt = make_frame(r_mem[r_rd_ptr]);
                        w_pop       = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETUP: begin
                // The parity bit's falling edge has not happened yet here.
                if (bus.inhibit && (r_idx <= PARITY_IDX)) begin
                    w_state_nxt = GAP;
                    w_tmr_nxt   = tmr_t'(0);
                    w_retry_nxt = 1'b1;
                end else begin
                    w_data_nxt = w_cur_bit;
                    if (r_tmr == HP_LAST) begin
                        w_state_nxt = CLK_LO;
                        w_tmr_nxt   = tmr_t'(0);
                    end else begin
                        w_state_nxt = SETUP;
                    end
                end
            end
            CLK_LO: begin
                // Once the parity bit has been clocked the frame is committed.
                if (bus.inhibit && (r_idx < PARITY_IDX)) begin
                    w_state_nxt = GAP;
                    w_tmr_nxt   = tmr_t'(0);
                    w_retry_nxt = 1'b1;
                end else begin
                    w_clk_nxt  = 1'b0;
                    w_data_nxt = w_cur_bit;
                    if (r_tmr == HP_LAST) begin
                        w_state_nxt = CLK_HI;
                        w_tmr_nxt   = tmr_t'(0);
                    end else begin
                        w_state_nxt = CLK_LO;
                    end
                end
            end
            CLK_HI: begin
                if (bus.inhibit && (r_idx < PARITY_IDX)) begin
                    w_state_nxt = GAP;
                    w_tmr_nxt   = tmr_t'(0);
                    w_retry_nxt = 1'b1;
                end else begin
                    w_data_nxt = w_cur_bit;
                    if (r_tmr == HALF_LAST) begin
                        w_tmr_nxt = tmr_t'(0);
                        if (r_idx == STOP_IDX) begin
                            w_state_nxt = GAP;
                        end else begin
                            w_idx_nxt   = r_idx + 4'd1;
                            w_state_nxt = SETUP;
                        end
                    end else begin
                        w_state_nxt = CLK_HI;
                    end
                end
            end
            GAP: begin
                if (r_tmr == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = tmr_t'(0);
                end else begin
                    w_state_nxt = GAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tmr_nxt   = tmr_t'(0);
                w_idx_nxt   = 4'd0;
                w_retry_nxt = 1'b0;
            end
        endcase
    end

    // Byte FIFO storage, pointers and status flags.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= ptr_t'(0);
            r_rd_ptr <= ptr_t'(0);
            r_count  <= occ_t'(0);
            r_full   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.din;
                r_wr_ptr        <= r_wr_ptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            r_busy  <= (w_state_nxt != IDLE) || (w_count_nxt != occ_t'(0)) || w_retry_nxt;
        end
    end

    // Sequencer state and registered PS/2 line drivers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tmr      <= tmr_t'(0);
            r_idx      <= 4'd0;
            r_frame    <= 11'h7FF;
            r_retry    <= 1'b0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_idx      <= w_idx_nxt;
            r_frame    <= w_frame_nxt;
            r_retry    <= w_retry_nxt;
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
        end
    end

    assign bus.full         = r_full;
    assign bus.busy         = r_busy;
    assign bus.ps2_kbd_clk  = r_ps2_clk;
    assign bus.ps2_kbd_data = r_ps2_data;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_kbd_tx
// Purpose : self-checking bench for ps2_kbd_tx with HALF_PERIOD=8,
//           GAP_HALVES=4, FIFO_DEPTH=4. A line monitor captures the data bit
//           at every falling PS/2 clock edge; frames are compared against
//           hand-computed 11-bit patterns (bit i = i-th bit on the wire).
// ----------------------------------------------------------------------------
module tb_ps2_kbd_tx;
    localparam int HP    = 8;
    localparam int GH    = 4;
    localparam int DEPTH = 4;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    ps2_kbd_tx_if bus();

    ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_HALVES(GH), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int viol    = 0;

    logic q_bits[$];
    int   q_tfall[$];
    int   q_tchg[$];
    int   last_start_chg;
    int   last_stop_fall;

    typedef struct {
        logic [7:0]  din;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs[8];

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Line monitor: records data at each clk fall and timing of data changes.
    initial begin
        logic prev_clk;
        logic prev_data;
        int   last_dchg;
        prev_clk  = 1'b1;
        prev_data = 1'b1;
        last_dchg = 0;
        forever begin
            @(negedge clk_sys);
            if (bus.ps2_kbd_data !== prev_data) begin
                if (prev_clk == 1'b0 && bus.ps2_kbd_clk == 1'b0) viol++;
                last_dchg = cyc;
            end
            if (prev_clk == 1'b1 && bus.ps2_kbd_clk == 1'b0) begin
                q_bits.push_back(bus.ps2_kbd_data);
                q_tfall.push_back(cyc);
                q_tchg.push_back(last_dchg);
                if (cyc - last_dchg < HP / 2) viol++;
            end
            prev_clk  = bus.ps2_kbd_clk;
            prev_data = bus.ps2_kbd_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.din = b;
        bus.we  = 1'b1;
        @(negedge clk_sys);
        bus.we  = 1'b0;
    endtask

    task automatic wait_bits(input string name, input int n);
        int waited = 0;
        while (q_bits.size() < n && waited < 2000) begin
            @(posedge clk_sys);
            waited++;
        end
        chk({name, "_timeout"}, (q_bits.size() >= n), 1);
        @(negedge clk_sys);
    endtask

    task automatic expect_frame(input string name, input logic [10:0] exp);
        logic [10:0] got;
        int t;
        int c;
        wait_bits(name, 11);
        if (q_bits.size() >= 11) begin
            for (int i = 0; i < 11; i++) begin
                got[i] = q_bits.pop_front();
                t = q_tfall.pop_front();
                c = q_tchg.pop_front();
                if (i == 0)  last_start_chg = c;
                if (i == 10) last_stop_fall = t;
            end
            chk(name, got, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int waited = 0;
        while (bus.busy && waited < 500) begin
            @(negedge clk_sys);
            waited++;
        end
        chk(name, bus.busy, 0);
    endtask

    task automatic clear_mon();
        q_bits.delete();
        q_tfall.delete();
        q_tchg.delete();
    endtask

    initial begin
        logic [3:0] part;
        int cyc_abort;

        vecs[0] = '{din: 8'h1C, frame: 11'b1_0_0001_1100_0};
        vecs[1] = '{din: 8'hF0, frame: 11'b1_1_1111_0000_0};
        vecs[2] = '{din: 8'h5A, frame: 11'b1_1_0101_1010_0};
        vecs[3] = '{din: 8'h00, frame: 11'b1_1_0000_0000_0};
        vecs[4] = '{din: 8'hFF, frame: 11'b1_1_1111_1111_0};
        vecs[5] = '{din: 8'h01, frame: 11'b1_0_0000_0001_0};
        vecs[6] = '{din: 8'h80, frame: 11'b1_0_1000_0000_0};
        vecs[7] = '{din: 8'h6B, frame: 11'b1_0_0110_1011_0};

        bus.din     = 8'h00;
        bus.we      = 1'b0;
        bus.inhibit = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_clk",  bus.ps2_kbd_clk, 1);
        chk("rst_data", bus.ps2_kbd_data, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // Latency: data falls to the start bit two edges after the write edge.
        write_byte(8'h1C);
        chk("lat_e0_data", bus.ps2_kbd_data, 1);
        chk("lat_e0_busy", bus.busy, 1);
        @(negedge clk_sys);
        chk("lat_e1_data", bus.ps2_kbd_data, 1);
        @(negedge clk_sys);
        chk("lat_e2_data", bus.ps2_kbd_data, 0);
        chk("lat_e2_clk",  bus.ps2_kbd_clk, 1);
        expect_frame("frame_1c", 11'b1_0_0001_1100_0);
        wait_idle("idle_1c");
        chk("extra_1c", q_bits.size(), 0);

        // Table-driven single-byte frames.
        for (int i = 0; i < 8; i++) begin
            write_byte(vecs[i].din);
            expect_frame($sformatf("vec%0d", i), vecs[i].frame);
            wait_idle($sformatf("vec%0d_idle", i));
            chk($sformatf("vec%0d_extra", i), q_bits.size(), 0);
        end

        // Back-to-back writes: order and inter-frame gap.
        write_byte(8'hF0);
        write_byte(8'h1C);
        expect_frame("b2b_first", 11'b1_1_1111_0000_0);
        cyc_abort = last_stop_fall;
        expect_frame("b2b_second", 11'b1_0_0001_1100_0);
        chk("b2b_gap", ((last_start_chg - cyc_abort) >= 4 * HP), 1);
        wait_idle("b2b_idle");

        // FIFO full under inhibit; fifth byte dropped.
        bus.inhibit = 1'b1;
        write_byte(8'h11);
        write_byte(8'h23);
        write_byte(8'h33);
        chk("fill_3_full", bus.full, 0);
        write_byte(8'h47);
        chk("fill_4_full", bus.full, 1);
        write_byte(8'h99);
        chk("fill_5_full", bus.full, 1);
        repeat (50) @(negedge clk_sys);
        chk("inh_no_frames", q_bits.size(), 0);
        chk("inh_busy", bus.busy, 1);
        bus.inhibit = 1'b0;
        expect_frame("fifo_f0", 11'b1_1_0001_0001_0);
        expect_frame("fifo_f1", 11'b1_0_0010_0011_0);
        expect_frame("fifo_f2", 11'b1_1_0011_0011_0);
        expect_frame("fifo_f3", 11'b1_1_0100_0111_0);
        wait_idle("fifo_idle");
        chk("fifo_dropped", q_bits.size(), 0);
        chk("fifo_full_end", bus.full, 0);

        // Inhibit after the parity edge does not abort; inhibit blocks start.
        write_byte(8'h01);
        wait_bits("post_par", 10);
        bus.inhibit = 1'b1;
        expect_frame("post_par_frame", 11'b1_0_0000_0001_0);
        write_byte(8'h80);
        repeat (150) @(negedge clk_sys);
        chk("inh_block", q_bits.size(), 0);
        chk("inh_block_busy", bus.busy, 1);
        bus.inhibit = 1'b0;
        expect_frame("inh_release", 11'b1_0_1000_0000_0);
        wait_idle("inh_release_idle");

        // Abort during data bit 3 of 0x5A and full resend.
        write_byte(8'h5A);
        wait_bits("abort", 4);
        repeat (13) @(negedge clk_sys);
        bus.inhibit = 1'b1;
        @(negedge clk_sys);
        bus.inhibit = 1'b0;
        cyc_abort = cyc;
        chk("abort_clk",  bus.ps2_kbd_clk, 1);
        chk("abort_data", bus.ps2_kbd_data, 1);
        chk("abort_busy", bus.busy, 1);
        chk("abort_partial_cnt", q_bits.size(), 4);
        if (q_bits.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                part[i] = q_bits.pop_front();
                void'(q_tfall.pop_front());
                void'(q_tchg.pop_front());
            end
            chk("abort_partial_bits", part, 4'b0100);
        end
        expect_frame("abort_resend", 11'b1_1_0101_1010_0);
        chk("abort_gap", ((last_start_chg - cyc_abort) >= GH * HP), 1);
        wait_idle("abort_idle");

        // Reset mid-frame with two bytes queued.
        bus.inhibit = 1'b1;
        write_byte(8'h12);
        write_byte(8'h34);
        write_byte(8'h56);
        bus.inhibit = 1'b0;
        wait_bits("rst_mid", 6);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b0;
        #1;
        chk("rstmid_clk",  bus.ps2_kbd_clk, 1);
        chk("rstmid_data", bus.ps2_kbd_data, 1);
        chk("rstmid_full", bus.full, 0);
        chk("rstmid_busy", bus.busy, 0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        clear_mon();
        repeat (300) @(negedge clk_sys);
        chk("rstmid_no_frames", q_bits.size(), 0);
        chk("rstmid_busy_after", bus.busy, 0);
        write_byte(8'h7E);
        expect_frame("rstmid_resume", 11'b1_1_0111_1110_0);
        wait_idle("rstmid_resume_idle");

        // Write on the same cycle as a pop at DEPTH-1 occupancy.
        bus.inhibit = 1'b1;
        write_byte(8'hA5);
        write_byte(8'h3C);
        write_byte(8'h81);
        chk("simul_pre_full", bus.full, 0);
        bus.inhibit = 1'b0;
        bus.din     = 8'h6B;
        bus.we      = 1'b1;
        @(negedge clk_sys);
        bus.we      = 1'b0;
        chk("simul_full", bus.full, 0);
        chk("simul_busy", bus.busy, 1);
        expect_frame("simul_f0", 11'b1_1_1010_0101_0);
        expect_frame("simul_f1", 11'b1_1_0011_1100_0);
        expect_frame("simul_f2", 11'b1_1_1000_0001_0);
        expect_frame("simul_f3", 11'b1_0_0110_1011_0);
        wait_idle("simul_idle");
        chk("simul_extra", q_bits.size(), 0);

        chk("line_timing", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
